// File: rtl/rate_step_controller_pkg.sv
// rtl/rate_step_controller_pkg.sv - rate encodings, default timing constants and rate helpers
package rate_step_controller_pkg;

   localparam int RATE_W = 2;

   typedef enum logic [RATE_W-1:0] {
      RATE_0 = 2'd0,
      RATE_1 = 2'd1,
      RATE_2 = 2'd2,
      RATE_3 = 2'd3
   } rate_t;

   localparam int DEF_DEBOUNCE_CYCLES = 200000;
   localparam int DEF_DIV0            = 10000000;
   localparam int DEF_DIV1            = 5000000;
   localparam int DEF_DIV2            = 2500000;
   localparam int DEF_DIV3            = 1000000;
   localparam int DEF_CNT_W           = 24;

   // RATE_3 wraps back to RATE_0 through the natural 2-bit overflow.
   function automatic rate_t next_rate(input rate_t r);
      return rate_t'(r + 2'd1);
   endfunction

   function automatic logic [3:0] rate_onehot(input rate_t r);
      return 4'b0001 << r;
   endfunction

endpackage

// File: rtl/rate_step_controller_debounce.sv
// rtl/rate_step_controller_debounce.sv - 2-FF synchronizer, level debounce and press pulse
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 200000
) (
   input  logic clk,
   input  logic reset,
   input  logic button_n,
   output logic press
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync_meta;
   logic            sync_level;
   logic            stable;
   logic [DB_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta  <= 1'b1;
         sync_level <= 1'b1;
         stable     <= 1'b1;
         count      <= '0;
         press      <= 1'b0;
      end else begin
         sync_meta  <= button_n;
         sync_level <= sync_meta;
         press      <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (sync_level == stable) begin
            count <= '0;
         end else if (count == DB_LAST) begin
            stable <= sync_level;
            count  <= '0;
            press  <= ~sync_level;
         end else begin
            count <= count + DB_W'(1);
         end
      end
   end

endmodule

// File: rtl/rate_step_controller.sv
// rtl/rate_step_controller.sv - debounced rate stepping FSM and tick prescaler
module rate_step_controller
   import rate_step_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DIV0            = DEF_DIV0,
   parameter int DIV1            = DEF_DIV1,
   parameter int DIV2            = DEF_DIV2,
   parameter int DIV3            = DEF_DIV3,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic              ADC_CLK_10,
   input  logic              reset,
   input  logic              step_n,
   input  logic              run,
   output logic              tick,
   output logic [RATE_W-1:0] rate_sel,
   output logic [3:0]        rate_led,
   output logic              step_pulse
);

   rate_t            state;
   logic             run_meta;
   logic             run_sync;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] term;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_debounce (
      .clk      (ADC_CLK_10),
      .reset    (reset),
      .button_n (step_n),
      .press    (step_pulse)
   );

   always_comb begin
      term = CNT_W'(DIV0 - 1);
      unique case (state)
         RATE_0: term = CNT_W'(DIV0 - 1);
         RATE_1: term = CNT_W'(DIV1 - 1);
         RATE_2: term = CNT_W'(DIV2 - 1);
         RATE_3: term = CNT_W'(DIV3 - 1);
         default: term = CNT_W'(DIV0 - 1);
      endcase
   end

   assign rate_sel = state;

   // A press outranks a terminal count: the prescaler restarts at the new rate
   // and the would-be tick is dropped, whether or not we are running.
   always_ff @(posedge ADC_CLK_10 or posedge reset) begin
      if (reset) begin
         state    <= RATE_0;
         rate_led <= 4'b0001;
         run_meta <= 1'b0;
         run_sync <= 1'b0;
         presc    <= '0;
         tick     <= 1'b0;
      end else begin
         run_meta <= run;
         run_sync <= run_meta;
         tick     <= 1'b0;
         if (step_pulse) begin
            state    <= next_rate(state);
            rate_led <= rate_onehot(next_rate(state));
            presc    <= '0;
         end else if (run_sync) begin
            if (presc == term) begin
               presc <= '0;
               tick  <= 1'b1;
            end else begin
               presc <= presc + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rate_step_controller.sv
// tb/tb_rate_step_controller.sv - scoreboard bench for rate_step_controller
module tb_rate_step_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       step_n;
   logic       run;
   logic       tick;
   logic [1:0] rate_sel;
   logic [3:0] rate_led;
   logic       step_pulse;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int h        = 0;
   int rate     = 0;
   int tick_q[$];
   int pulse_q[$];

   rate_step_controller #(
      .DEBOUNCE_CYCLES(4),
      .DIV0(8),
      .DIV1(4),
      .DIV2(2),
      .DIV3(1),
      .CNT_W(24)
   ) dut (
      .ADC_CLK_10 (clk),
      .reset      (reset),
      .step_n     (step_n),
      .run        (run),
      .tick       (tick),
      .rate_sel   (rate_sel),
      .rate_led   (rate_led),
      .step_pulse (step_pulse)
   );

   always #50 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d exceeded limit %0d", cyc, 20000);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int div_of(input int r);
      case (r)
         0: return 8;
         1: return 4;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   // Scoreboard consumers: every observed tick/pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (tick !== 1'b0) begin
         if (tick_q.size() == 0) check("tick_unexpected", {31'd0, tick}, 0);
         else check("tick_cycle", cyc, tick_q.pop_front());
      end
      if (step_pulse !== 1'b0) begin
         if (pulse_q.size() == 0) check("pulse_unexpected", {31'd0, step_pulse}, 0);
         else check("pulse_cycle", cyc, pulse_q.pop_front());
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle_state(input string tag);
      check({tag, "_tick"}, {31'd0, tick}, 0);
      check({tag, "_pulse"}, {31'd0, step_pulse}, 0);
      check({tag, "_rate_sel"}, {30'd0, rate_sel}, 0);
      check({tag, "_rate_led"}, {28'd0, rate_led}, 1);
   endtask

   // Counting edges run from s+3 to s+n+2 once run is driven high right after edge s.
   task automatic run_span(input int n);
      int s;
      int d;
      d = div_of(rate);
      run = 1'b1;
      s = cyc;
      for (int k = 1; k <= n; k++)
         if ((h + k) % d == 0) tick_q.push_back(s + 2 + k);
      wait_cycles(n);
      run = 1'b0;
      wait_cycles(3);
      h = (h + n) % d;
      check("tick_missing", tick_q.size(), 0);
      tick_q.delete();
   endtask

   task automatic press(input int hold);
      int p;
      step_n = 1'b0;
      p = cyc;
      pulse_q.push_back(p + 6);
      wait_cycles(hold);
      step_n = 1'b1;
      wait_cycles(12);
      rate = (rate + 1) % 4;
      h = 0;
      check("pulse_missing", pulse_q.size(), 0);
      pulse_q.delete();
      check("rate_sel", {30'd0, rate_sel}, rate);
      check("rate_led", {28'd0, rate_led}, 1 << rate);
   endtask

   // Press lined up so the advance edge coincides with a terminal count.
   task automatic press_on_terminal();
      int s, d, nd, k0, te, p;
      d = div_of(rate);
      run = 1'b1;
      s = cyc;
      k0 = d - (h % d);
      te = s + 2 + k0 + d;
      tick_q.push_back(s + 2 + k0);
      p = te - 7;
      wait_cycles(p - s);
      step_n = 1'b0;
      pulse_q.push_back(p + 6);
      nd = div_of((rate + 1) % 4);
      for (int j = 1; te + nd * j <= te + 19; j++) tick_q.push_back(te + nd * j);
      wait_cycles(8);
      step_n = 1'b1;
      rate = (rate + 1) % 4;
      wait_cycles(te + 17 - cyc);
      run = 1'b0;
      wait_cycles(3);
      h = 19 % nd;
      check("collide_tick_missing", tick_q.size(), 0);
      check("collide_pulse_missing", pulse_q.size(), 0);
      check("collide_rate_sel", {30'd0, rate_sel}, rate);
      tick_q.delete();
      pulse_q.delete();
   endtask

   initial begin
      int r0;
      reset  = 1'b1;
      run    = 1'b1;
      step_n = 1'b1;
      wait_cycles(3);
      check_idle_state("reset");

      reset = 1'b0;
      r0 = cyc;
      tick_q.push_back(r0 + 10);
      tick_q.push_back(r0 + 18);
      wait_cycles(23);
      reset = 1'b1;
      #1;
      check_idle_state("midreset");
      wait_cycles(3);
      check("pre_reset_ticks", tick_q.size(), 0);
      tick_q.delete();
      reset = 1'b0;
      h = 0;
      rate = 0;
      run_span(50);

      step_n = 1'b0;
      wait_cycles(3);
      step_n = 1'b1;
      wait_cycles(12);
      check("glitch_rate_sel", {30'd0, rate_sel}, 0);

      run_span(20);
      press(20);
      run_span(12);
      for (int i = 0; i < 3; i++) begin
         press(8);
         run_span(20);
      end

      press_on_terminal();
      wait_cycles(10);
      run_span(20);

      reset = 1'b1;
      #1;
      check_idle_state("final_reset");
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(3);
      check_idle_state("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
